// File: rtl/if_stage.sv
// if_stage: program counter, IF/ID register and an 8-deep return-address stack for CALL/RET.
module if_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [18:0] imem_addr,
    input  logic [18:0] imem_rdata,
    input  logic        id_jump,
    input  logic        id_push,
    input  logic        id_ret,
    input  logic [18:0] id_jump_target,
    input  logic        ex_branch_taken,
    input  logic [18:0] ex_branch_target,
    output logic [18:0] if_id_instr,
    output logic [18:0] if_id_pc,
    output logic        if_id_valid,
    output logic        ras_overflow,
    output logic        ras_underflow
);
    logic [18:0] pc;
    logic [18:0] ras [8];
    logic [3:0]  sp;
    logic [2:0]  top_idx;
    logic        idq, do_ret, do_push, do_jmp, redirect;
    logic [18:0] ras_top, next_pc;

    assign imem_addr = pc;

    always_comb begin
        idq      = if_id_valid & ~stall & ~ex_branch_taken;
        do_ret   = idq & id_ret;
        do_push  = idq & id_push & ~id_ret;
        do_jmp   = idq & id_jump;
        redirect = ex_branch_taken | do_ret | do_jmp;
        top_idx  = sp[2:0] - 3'd1;
        ras_top  = (sp == 4'd0) ? 19'd0 : ras[top_idx];
        next_pc  = ex_branch_taken ? ex_branch_target :
                   do_ret          ? ras_top :
                   do_jmp          ? id_jump_target :
                   stall           ? pc : pc + 19'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= '0;
            if_id_instr   <= '0;
            if_id_pc      <= '0;
            if_id_valid   <= 1'b0;
            sp            <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc <= next_pc;
            if (redirect) begin
                if_id_instr <= '0;
                if_id_pc    <= '0;
                if_id_valid <= 1'b0;
            end else if (!stall) begin
                if_id_instr <= imem_rdata;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
            end
            if (do_ret) begin
                if (sp == 4'd0) ras_underflow <= 1'b1;
                else sp <= sp - 4'd1;
            end else if (do_push) begin
                if (sp[3]) ras_overflow <= 1'b1;
                else sp <= sp + 4'd1;
            end
        end
    end

    // stack storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (do_push && !sp[3]) ras[sp[2:0]] <= if_id_pc + 19'd1;
    end
endmodule
